hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Stall/flush controller that drives the enable, clear and bubble inputs of the IF/ID and ID/EX pipeline registers and the PC enable. It detects load-use hazards, flushes on taken branches and jumps resolved in EX, and stalls HI/LO consumers while a multi-cycle MULT/DIV is in flight. It halts the pipeline on a SYSCALL retiring in WB. It sits beside the IF/ID/EX register chain and takes inputs from ID decode and from the ID/EX and WB register outputs.

Parameters:
MD_LATENCY, 4, total cycles of a MULT/DIV including the issue cycle; minimum 1, and 1 means never busy.
CNT_W, $clog2(MD_LATENCY+1), width of the MULT/DIV busy counter.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst_n  in  1  synchronous active-low reset.
id_rs  in  5  rs field of the instruction in ID.
id_rt  in  5  rt field of the instruction in ID.
id_use_rs  in  1  ID instruction reads rs.
id_use_rt  in  1  ID instruction reads rt.
id_use_hilo  in  1  ID instruction reads or writes HI/LO (MFHI, MFLO, MTHI, MTLO, MULT, DIV).
ex_wb_reg  in  5  WbRegNum of the instruction in EX.
ex_reg_write  in  1  RegWrite of the instruction in EX.
ex_mem_to_reg  in  1  MemtoReg of the instruction in EX (load).
ex_redirect  in  1  taken branch or jump resolved in EX.
md_start  in  1  MULT/DIV issuing in EX this cycle.
wb_syscall  in  1  halting SYSCALL retiring in WB.
pc_en  out  1  PC load enable.
ifid_en  out  1  IF/ID enable.
ifid_clr  out  1  IF/ID clear.
idex_en  out  1  ID/EX enable.
idex_clr  out  1  ID/EX clear (stall bubble).
bb  out  1  ID/EX branch bubble (redirect flush).
halted  out  1  pipeline halted, sticky.

Behaviour:
- The state machine has three states: RUN, MD_BUSY and HALT. The busy counter is md_cnt[CNT_W-1:0].
- Reset, sampled at the posedge when rst_n=0, forces:
  - state=RUN, md_cnt=0, halted=0.
  - While rst_n=0 the outputs are combinationally forced to pc_en=0, ifid_en=0, idex_en=0, ifid_clr=1, idex_clr=1, bb=0.
  - Reset mid-MULT/DIV discards the busy count.
- Outputs are combinational from state and the current inputs. There is no added latency.
- load_use = ex_mem_to_reg & ex_reg_write & (ex_wb_reg!=0) & ((id_use_rs & id_rs==ex_wb_reg) | (id_use_rt & id_rt==ex_wb_reg)).
- md_stall = id_use_hilo & ((state==MD_BUSY) | (md_start & MD_LATENCY>1)).
- Output priority, highest first:
  - HALT state: all enables=0, all clears=0, bb=0.
  - ex_redirect=1: pc_en=1, ifid_en=1, ifid_clr=1, idex_en=1, bb=1, idex_clr=0. The younger stalled instructions are squashed, so no stall is applied.
  - md_stall or load_use: pc_en=0, ifid_en=0, ifid_clr=0, idex_en=1, idex_clr=1, bb=0. This holds IF/ID and inserts one bubble per cycle.
  - Otherwise: pc_en=1, ifid_en=1, idex_en=1, all clears=0, bb=0.
- State transitions:
  - Any state except HALT, with wb_syscall=1 → HALT. This has the highest priority. HALT is left only by reset, and halted=1 in HALT.
  - RUN, md_start=1, MD_LATENCY>1 → MD_BUSY, with md_cnt<=MD_LATENCY-1.
  - MD_BUSY, md_start=1 → stays in MD_BUSY with md_cnt reloaded to MD_LATENCY-1. The newer op restarts the count.
  - MD_BUSY, md_cnt==1, md_start=0 → RUN, with md_cnt<=0. Otherwise md_cnt decrements by 1.
- Simultaneous ex_redirect and md_start is illegal (both come from the same EX instruction). The bench asserts against it. If it occurs, both actions are honoured.
- A load-use stall lasts exactly one cycle: the bubble clears ex_mem_to_reg next cycle.
- Writes to $0 never stall.

Optional Feature:
HAZARD_STATS_EN. When defined, the block adds 32-bit outputs stall_cycles and flush_count.
- stall_cycles increments on every cycle in which the stall row of the priority list is active.
- flush_count increments on every cycle in which the redirect row is active.
- Both counters reset to 0, saturate at 32'hFFFFFFFF, and freeze in HALT.
When the macro is undefined, those ports and registers are absent.

Decomposition:
- Shared package pipe_pkg holds the state enum (RUN=2'd0, MD_BUSY=2'd1, HALT=2'd2), REG_ZERO=5'd0 and the register-number width 5.
- One natural sub-module, md_busy_counter, owns md_cnt and the reload/decrement logic and produces md_busy.
- The top block keeps the FSM and the output priority mux.

Test Plan:
- Load-use: EX has a load with ex_wb_reg=8; ID has id_rs=8, id_use_rs=1 → one cycle with pc_en=0, ifid_en=0, idex_clr=1; the next cycle is a normal advance.
- $0 and no-use: the EX load has ex_wb_reg=0 and matches id_rt=0; separately, ex_wb_reg=9 matches id_rt=9 with id_use_rt=0 → no stall in either case.
- Redirect during load-use: ex_redirect=1 with the load-use condition true → pc_en=1, ifid_clr=1, bb=1, idex_clr=0.
- MULT/DIV with MD_LATENCY=4: md_start at cycle 0 and id_use_hilo held → stall in cycles 0-3 and issue in cycle 4. A second md_start at cycle 2 extends the stall through cycle 5.
- Halt: wb_syscall pulsed → from the next cycle halted=1 and all enables 0. A later ex_redirect or md_start is ignored. Holding rst_n=0 for one cycle returns to RUN with halted=0.
- Reset mid-busy: rst_n=0 at cycle 2 of a MULT/DIV → state RUN and md_cnt=0 after reset, and id_use_hilo does not stall.
- With HAZARD_STATS_EN: one load-use stall plus two redirects → stall_cycles=1, flush_count=2.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared encodings for the pipeline hazard/stall controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        HALT    = 2'd2
    } state_e;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MD_BUSY = 2'd1;
    localparam logic [1:0] ST_HALT    = 2'd2;

    function automatic logic reg_match(input logic use_f,
                                       input logic [REG_W-1:0] a,
                                       input logic [REG_W-1:0] b);
        return use_f && (a == b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl_if
// Description : Decode/EX/WB hazard inputs and pipeline-register controls.
//               HAZARD_STATS_EN adds the stall/flush statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_stall_ctrl_if;
    import pipe_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_use_hilo;
    logic [REG_W-1:0] ex_wb_reg;
    logic             ex_reg_write;
    logic             ex_mem_to_reg;
    logic             ex_redirect;
    logic             md_start;
    logic             wb_syscall;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_clr;
    logic             idex_en;
    logic             idex_clr;
    logic             bb;
    logic             halted;
`ifdef HAZARD_STATS_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      flush_count;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_use_hilo,
               ex_wb_reg, ex_reg_write, ex_mem_to_reg, ex_redirect,
               md_start, wb_syscall,
        input  pc_en, ifid_en, ifid_clr, idex_en, idex_clr, bb, halted,
               stall_cycles, flush_count
    );
    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_use_hilo,
               ex_wb_reg, ex_reg_write, ex_mem_to_reg, ex_redirect,
               md_start, wb_syscall,
        output pc_en, ifid_en, ifid_clr, idex_en, idex_clr, bb, halted,
               stall_cycles, flush_count
    );
`else
    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_use_hilo,
               ex_wb_reg, ex_reg_write, ex_mem_to_reg, ex_redirect,
               md_start, wb_syscall,
        input  pc_en, ifid_en, ifid_clr, idex_en, idex_clr, bb, halted
    );
    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_use_hilo,
               ex_wb_reg, ex_reg_write, ex_mem_to_reg, ex_redirect,
               md_start, wb_syscall,
        output pc_en, ifid_en, ifid_clr, idex_en, idex_clr, bb, halted
    );
`endif

endinterface
`default_nettype wire

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
`default_nettype none
// ============================================================================
// Module      : md_busy_counter
// Description : Tracks remaining cycles of an in-flight MULT/DIV.
// Revision    : 1.0 - initial release
// ============================================================================
module md_busy_counter #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = $clog2(MD_LATENCY + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_load,
    input  wire logic             i_dec,
    output logic [CNT_W-1:0]      o_md_cnt,
    output logic                  o_md_busy
);

    localparam logic [CNT_W-1:0] c_reload = CNT_W'(MD_LATENCY - 1);

    logic [CNT_W-1:0] r_md_cnt;

    // A new issue always restarts the count, even mid-operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_md_cnt <= '0;
        end else if (i_load) begin
            r_md_cnt <= c_reload;
        end else if (i_dec && (r_md_cnt != '0)) begin
            r_md_cnt <= r_md_cnt - CNT_W'(1);
        end
    end

    assign o_md_cnt  = r_md_cnt;
    assign o_md_busy = (r_md_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Load-use / MULT-DIV stall, redirect flush and SYSCALL halt
//               control. Optional macro HAZARD_STATS_EN adds stat counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = $clog2(MD_LATENCY + 1)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    hazard_stall_ctrl_if.slave bus
);

    localparam logic c_md_multi = (MD_LATENCY > 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_md_cnt;
    logic             w_md_busy;
    logic             w_md_load;
    logic             w_md_dec;
    logic             w_load_use;
    logic             w_md_stall;
    logic             w_stall_row;
    logic             w_redirect_row;

    assign w_md_load = bus.md_start && c_md_multi && (r_state != ST_HALT) && !bus.wb_syscall;
    assign w_md_dec  = (r_state == ST_MD_BUSY) && !bus.md_start && !bus.wb_syscall;

    md_busy_counter #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_busy_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_md_load),
        .i_dec     (w_md_dec),
        .o_md_cnt  (w_md_cnt),
        .o_md_busy (w_md_busy)
    );

    assign w_load_use = bus.ex_mem_to_reg && bus.ex_reg_write && (bus.ex_wb_reg != REG_ZERO) &&
                        (reg_match(bus.id_use_rs, bus.id_rs, bus.ex_wb_reg) ||
                         reg_match(bus.id_use_rt, bus.id_rt, bus.ex_wb_reg));

    assign w_md_stall = bus.id_use_hilo &&
                        (((r_state == ST_MD_BUSY) && w_md_busy) || (bus.md_start && c_md_multi));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (bus.wb_syscall)   w_state_nxt = ST_HALT;
                else if (w_md_load)   w_state_nxt = ST_MD_BUSY;
            end
            ST_MD_BUSY: begin
                if (bus.wb_syscall)   w_state_nxt = ST_HALT;
                else if (!bus.md_start && (w_md_cnt == CNT_W'(1)))
                                      w_state_nxt = ST_RUN;
            end
            ST_HALT:                  w_state_nxt = ST_HALT;
            default:                  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    assign w_redirect_row = rst_n && (r_state != ST_HALT) && bus.ex_redirect;
    assign w_stall_row    = rst_n && (r_state != ST_HALT) && !bus.ex_redirect &&
                            (w_md_stall || w_load_use);

    // Priority: reset, halt, redirect flush, stall bubble, normal advance.
    always_comb begin
        bus.pc_en    = 1'b1;
        bus.ifid_en  = 1'b1;
        bus.ifid_clr = 1'b0;
        bus.idex_en  = 1'b1;
        bus.idex_clr = 1'b0;
        bus.bb       = 1'b0;
        if (!rst_n) begin
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
            bus.ifid_clr = 1'b1;
            bus.idex_clr = 1'b1;
        end else if (r_state == ST_HALT) begin
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
        end else if (bus.ex_redirect) begin
            bus.ifid_clr = 1'b1;
            bus.bb       = 1'b1;
        end else if (w_md_stall || w_load_use) begin
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_clr = 1'b1;
        end
    end

    assign bus.halted = (r_state == ST_HALT);

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_row && (r_stall_cycles != 32'hFFFF_FFFF))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_redirect_row && (r_flush_count != 32'hFFFF_FFFF))
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;
`else
    logic w_unused_rows;
    assign w_unused_rows = w_stall_row ^ w_redirect_row;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Directed vector bench for hazard_stall_ctrl (MD_LATENCY=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    // {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, bb, halted}
    localparam logic [6:0] c_normal = 7'b1101000;
    localparam logic [6:0] c_stall  = 7'b0001100;
    localparam logic [6:0] c_redir  = 7'b1111010;
    localparam logic [6:0] c_halt   = 7'b0000001;
    localparam logic [6:0] c_rst    = 7'b0010100;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       use_hilo;
        logic [4:0] wb_reg;
        logic       reg_write;
        logic       mem_to_reg;
        logic       redirect;
        logic [6:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    vec_t vecs[11];

    hazard_stall_ctrl_if bus();

    hazard_stall_ctrl #(.MD_LATENCY(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (!(bus.ex_redirect && bus.md_start))
            else $error("illegal ex_redirect with md_start");
    end

    task automatic chk(input string name, input logic [6:0] exp);
        logic [6:0] act;
        #2;
        act = {bus.pc_en, bus.ifid_en, bus.ifid_clr, bus.idex_en, bus.idex_clr, bus.bb, bus.halted};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_in();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 0; bus.id_use_rt = 0;
        bus.id_use_hilo = 0; bus.ex_wb_reg = '0; bus.ex_reg_write = 0;
        bus.ex_mem_to_reg = 0; bus.ex_redirect = 0; bus.md_start = 0; bus.wb_syscall = 0;
    endtask

    task automatic apply(input vec_t v);
        bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_use_rs = v.use_rs; bus.id_use_rt = v.use_rt;
        bus.id_use_hilo = v.use_hilo; bus.ex_wb_reg = v.wb_reg; bus.ex_reg_write = v.reg_write;
        bus.ex_mem_to_reg = v.mem_to_reg; bus.ex_redirect = v.redirect;
        bus.md_start = 0; bus.wb_syscall = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        //         rs  rt  urs urt hilo wb  rw  m2r red  exp
        vecs[0]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0,  0, 0, 0, c_normal};
        vecs[1]  = '{5'd8, 5'd3, 1, 1, 0, 5'd8,  1, 1, 0, c_stall};
        vecs[2]  = '{5'd4, 5'd0, 1, 1, 0, 5'd0,  1, 1, 0, c_normal};
        vecs[3]  = '{5'd4, 5'd9, 1, 0, 0, 5'd9,  1, 1, 0, c_normal};
        vecs[4]  = '{5'd4, 5'd9, 0, 1, 0, 5'd9,  1, 1, 0, c_stall};
        vecs[5]  = '{5'd8, 5'd3, 1, 1, 0, 5'd8,  1, 0, 0, c_normal};
        vecs[6]  = '{5'd8, 5'd3, 1, 1, 0, 5'd8,  0, 1, 0, c_normal};
        vecs[7]  = '{5'd8, 5'd3, 1, 1, 0, 5'd8,  1, 1, 1, c_redir};
        vecs[8]  = '{5'd1, 5'd2, 0, 0, 0, 5'd5,  0, 0, 1, c_redir};
        vecs[9]  = '{5'd1, 5'd2, 0, 0, 1, 5'd5,  0, 0, 0, c_normal};
        vecs[10] = '{5'd8, 5'd31, 0, 1, 0, 5'd31, 1, 1, 0, c_stall};

        clear_in();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset", c_rst);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_reset", c_normal);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Load-use lasts one cycle once the bubble reaches EX.
        @(negedge clk);
        apply(vecs[1]);
        chk("lu_stall", c_stall);
        @(negedge clk);
        clear_in();
        bus.id_rs = 5'd8; bus.id_use_rs = 1;
        chk("lu_advance", c_normal);

        // Single MULT/DIV: stall cycles 0-3, issue in cycle 4.
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            clear_in();
            bus.id_use_hilo = 1;
            bus.md_start = (c == 0);
            chk($sformatf("md1_c%0d", c), (c < 4) ? c_stall : c_normal);
        end

        // Restart at cycle 2 extends the stall through cycle 5.
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            clear_in();
            bus.id_use_hilo = 1;
            bus.md_start = (c == 0) || (c == 2);
            chk($sformatf("md2_c%0d", c), (c < 6) ? c_stall : c_normal);
        end

        // Halt is sticky and ignores redirect and MULT/DIV issue.
        @(negedge clk);
        clear_in();
        bus.wb_syscall = 1;
        chk("syscall_cycle", c_normal);
        @(negedge clk);
        bus.wb_syscall = 0;
        chk("halted", c_halt);
        @(negedge clk);
        bus.ex_redirect = 1;
        chk("halt_redirect", c_halt);
        @(negedge clk);
        bus.ex_redirect = 0;
        bus.md_start = 1;
        bus.id_use_hilo = 1;
        chk("halt_md", c_halt);
        @(negedge clk);
        clear_in();
        rst_n = 1'b0;
        @(posedge clk);
        chk("halt_reset", c_rst);
        @(negedge clk);
        rst_n = 1'b1;
        chk("halt_release", c_normal);

        // Reset during a MULT/DIV discards the busy count.
        @(negedge clk);
        clear_in();
        bus.md_start = 1; bus.id_use_hilo = 1;
        chk("mdrst_c0", c_stall);
        @(negedge clk);
        bus.md_start = 0;
        chk("mdrst_c1", c_stall);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        chk("mdrst_reset", c_rst);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mdrst_hilo0", c_normal);
        @(negedge clk);
        chk("mdrst_hilo1", c_normal);

`ifdef HAZARD_STATS_EN
        @(negedge clk);
        clear_in();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(vecs[1]);
        @(negedge clk);
        apply(vecs[8]);
        @(negedge clk);
        apply(vecs[7]);
        @(negedge clk);
        clear_in();
        #2;
        chk32("stall_cycles", bus.stall_cycles, 32'd1);
        chk32("flush_count", bus.flush_count, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
